lamp_fpu_round_out: RTL and testbench

LAMP_FPU_ROUND_OUT -- requirements
Module: lamp_fpu_round_out

---
 rtl/lampFPU_pkg.sv | 66 ++++++
 rtl/lamp_fpu_round_out_res_fifo.sv | 57 +++++
 rtl/lamp_fpu_round_out.sv | 78 +++++++
 tb/tb_lamp_fpu_round_out.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/lampFPU_pkg.sv
// lampFPU shared definitions: float field widths, special-value encodings and
// the round-to-nearest-even helper used by the output rounding stage.
package lampFPU_pkg;

  localparam int LAMP_FLOAT_E_DW = 8;
  localparam int LAMP_FLOAT_F_DW = 7;
  localparam int LAMP_FLOAT_DW   = 1 + LAMP_FLOAT_E_DW + LAMP_FLOAT_F_DW;

  // {exponent, fraction} encodings of the special values (sign kept separately)
  localparam logic [LAMP_FLOAT_E_DW+LAMP_FLOAT_F_DW-1:0] INF_E_F  =
    {{LAMP_FLOAT_E_DW{1'b1}}, {LAMP_FLOAT_F_DW{1'b0}}};
  localparam logic [LAMP_FLOAT_E_DW+LAMP_FLOAT_F_DW-1:0] ZERO_E_F =
    {(LAMP_FLOAT_E_DW+LAMP_FLOAT_F_DW){1'b0}};

  // Rounded result plus {overflow, underflow, inexact}; packs as {s,e,f,flags}
  typedef struct packed {
    logic                       s;
    logic [LAMP_FLOAT_E_DW-1:0] e;
    logic [LAMP_FLOAT_F_DW-1:0] f;
    logic [2:0]                 flags;
  } rndRes_t;

  // f layout: [F+4:F+3] integer bits, [F+2:3] fraction, [2] G, [1] R, [0] S.
  // Only the fraction and G/R/S take part; the integer bits carry no extra
  // information once the exponent is biased.
  function automatic rndRes_t FUNC_rndNearestEven(
    input logic                       s,
    input logic [LAMP_FLOAT_E_DW-1:0] e,
    input logic [LAMP_FLOAT_F_DW+4:0] f,
    input logic                       isToRound
  );
    rndRes_t                    res;
    logic                       lsb;
    logic                       inc;
    logic                       inexact;
    logic [LAMP_FLOAT_F_DW:0]   fracSum;
    logic [LAMP_FLOAT_E_DW:0]   expSum;
    lsb     = f[3];
    inc     = f[2] & (f[1] | f[0] | lsb);
    inexact = f[2] | f[1] | f[0];
    fracSum = {1'b0, f[LAMP_FLOAT_F_DW+2:3]} + {{LAMP_FLOAT_F_DW{1'b0}}, inc};
    // fraction carry-out bumps the exponent; fracSum low bits are then zero
    expSum  = {1'b0, e} + {{LAMP_FLOAT_E_DW{1'b0}}, fracSum[LAMP_FLOAT_F_DW]};
    if (!isToRound) begin
      res.s     = s;
      res.e     = e;
      res.f     = f[LAMP_FLOAT_F_DW+2:3];
      res.flags = 3'b000;
    end else if (e == {LAMP_FLOAT_E_DW{1'b0}}) begin
      res.s            = s;
      {res.e, res.f}   = ZERO_E_F;
      res.flags        = 3'b011;
    end else if (expSum >= {1'b0, {LAMP_FLOAT_E_DW{1'b1}}}) begin
      res.s            = s;
      {res.e, res.f}   = INF_E_F;
      res.flags        = {1'b1, 1'b0, inexact};
    end else begin
      res.s     = s;
      res.e     = expSum[LAMP_FLOAT_E_DW-1:0];
      res.f     = fracSum[LAMP_FLOAT_F_DW-1:0];
      res.flags = {2'b00, inexact};
    end
    return res;
  endfunction

endpackage

// File: rtl/lamp_fpu_round_out_res_fifo.sv
// Synchronous first-word-fall-through FIFO holding rounded results until the
// writeback stage accepts them. Pointers wrap naturally (power-of-two depth).
module lamp_fpu_res_fifo #(
  parameter int FIFO_DEPTH = 2,
  parameter int DW         = 19
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wrEn_i,
  input  logic [DW-1:0]                 wrData_i,
  input  logic                          rdEn_i,
  output logic [DW-1:0]                 rdData_o,
  output logic                          valid_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  logic [DW-1:0]    mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtr_r;
  logic [PTR_W-1:0] rdPtr_r;
  logic [CNT_W-1:0] count_r;
  logic             popS;

  assign popS     = rdEn_i & valid_o;
  assign valid_o  = (count_r != {CNT_W{1'b0}});
  assign rdData_o = mem[rdPtr_r];
  assign count_o  = count_r;

  // Storage, pointers and occupancy; a push into a full FIFO only happens
  // together with a pop, so the slot being overwritten is the one leaving.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= {DW{1'b0}};
      wrPtr_r <= {PTR_W{1'b0}};
      rdPtr_r <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      if (wrEn_i) begin
        mem[wrPtr_r] <= wrData_i;
        wrPtr_r      <= wrPtr_r + PTR_ONE;
      end
      if (popS) begin
        rdPtr_r <= rdPtr_r + PTR_ONE;
      end
      case ({wrEn_i, popS})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/lamp_fpu_round_out.sv
// Output stage of the sqrt/invsqrt unit: rounds to nearest even, registers the
// result, and buffers it in a small FWFT FIFO with valid/ready writeback.
module lamp_fpu_round_out
  import lampFPU_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid_i,
  input  logic                       s_i,
  input  logic [LAMP_FLOAT_E_DW-1:0] e_i,
  input  logic [LAMP_FLOAT_F_DW+4:0] f_i,
  input  logic                       isToRound_i,
  output logic                       ready_o,
  output logic [LAMP_FLOAT_DW-1:0]   res_o,
  output logic [2:0]                 flags_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic                       drop_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int DW    = LAMP_FLOAT_DW + 3;

  rndRes_t          rndS;
  rndRes_t          stgData_r;
  logic             stgValid_r;
  logic             drop_r;
  logic             readyS;
  logic [CNT_W-1:0] fifoCount;
  logic [CNT_W:0]   occupancy;
  logic [DW-1:0]    fifoData;

  assign rndS = FUNC_rndNearestEven(s_i, e_i, f_i, isToRound_i);

  // The stage-1 entry is counted as already occupying a FIFO slot, so every
  // accepted input is guaranteed room when it leaves stage 1.
  assign occupancy = {1'b0, fifoCount} + {{CNT_W{1'b0}}, stgValid_r};
  assign readyS    = (occupancy < (CNT_W+1)'(FIFO_DEPTH));
  assign ready_o   = readyS;
  assign drop_o    = drop_r;

  // Stage-1 result register and sticky overrun flag
  always_ff @(posedge clk) begin
    if (rst) begin
      stgValid_r <= 1'b0;
      stgData_r  <= '{s: 1'b0, e: {LAMP_FLOAT_E_DW{1'b0}}, f: {LAMP_FLOAT_F_DW{1'b0}}, flags: 3'b000};
      drop_r     <= 1'b0;
    end else begin
      stgValid_r <= valid_i & readyS;
      if (valid_i & readyS) begin
        stgData_r <= rndS;
      end
      if (valid_i & ~readyS) begin
        drop_r <= 1'b1;
      end
    end
  end

  lamp_fpu_res_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DW         (DW)
  ) u_resFifo (
    .clk      (clk),
    .rst      (rst),
    .wrEn_i   (stgValid_r),
    .wrData_i (stgData_r),
    .rdEn_i   (ready_i),
    .rdData_o (fifoData),
    .valid_o  (valid_o),
    .count_o  (fifoCount)
  );

  assign res_o   = fifoData[DW-1:3];
  assign flags_o = fifoData[2:0];

endmodule

// File: tb/tb_lamp_fpu_round_out.sv
// Directed bench for lamp_fpu_round_out (bfloat16). Expected {res,flags}
// values are hand-derived constants queued when an input is accepted and
// compared when the DUT hands a result to writeback.
module tb_lamp_fpu_round_out;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic        s_i;
  logic [7:0]  e_i;
  logic [11:0] f_i;
  logic        isToRound_i;
  logic        ready_o;
  logic [15:0] res_o;
  logic [2:0]  flags_o;
  logic        valid_o;
  logic        ready_i;
  logic        drop_o;

  int vectors = 0;
  int miscompares = 0;
  logic [18:0] expQ [$];

  lamp_fpu_round_out #(.FIFO_DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid_i),
    .s_i         (s_i),
    .e_i         (e_i),
    .f_i         (f_i),
    .isToRound_i (isToRound_i),
    .ready_o     (ready_o),
    .res_o       (res_o),
    .flags_o     (flags_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .drop_o      (drop_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare every result taken by writeback against the queue
  always @(negedge clk) begin
    if (!rst && valid_o && ready_i) begin
      if (expQ.size() == 0) begin
        check("unexpected_output", {31'd0, valid_o}, 32'd0);
      end else begin
        check("result", {13'd0, res_o, flags_o}, {13'd0, expQ.pop_front()});
      end
    end
  end

  // Drive one input for one cycle once ready_o allows; optionally queue expectation
  task automatic send(input logic s, input logic [7:0] e, input logic [11:0] f,
                      input logic isR, input logic [15:0] r, input logic [2:0] fl,
                      input logic expectAccept);
    int n = 0;
    while (expectAccept && !ready_o && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("ready_before_send", {31'd0, ready_o}, {31'd0, expectAccept});
    valid_i = 1'b1; s_i = s; e_i = e; f_i = f; isToRound_i = isR;
    if (expectAccept) expQ.push_back({r, fl});
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (expQ.size() != 0 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("drain_done", expQ.size(), 32'd0);
  endtask

  logic [15:0] heldRes;

  initial begin
    rst = 1'b1; valid_i = 1'b0; s_i = 1'b0; e_i = 8'h00; f_i = 12'h000;
    isToRound_i = 1'b1; ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_valid_o", {31'd0, valid_o}, 32'd0);
    check("rst_ready_o", {31'd0, ready_o}, 32'd1);
    check("rst_res_o",   {16'd0, res_o},   32'd0);
    check("rst_flags_o", {29'd0, flags_o}, 32'd0);
    check("rst_drop_o",  {31'd0, drop_o},  32'd0);
    @(posedge clk); #1;

    // Latency: valid_i in cycle N, valid_o first seen in cycle N+2
    valid_i = 1'b1; s_i = 1'b0; e_i = 8'h7F; f_i = 12'h0FF; isToRound_i = 1'b1;
    expQ.push_back({16'h3FA0, 3'b001});
    @(negedge clk); check("lat_N",  {31'd0, valid_o}, 32'd0);
    @(posedge clk); #1 valid_i = 1'b0;
    @(negedge clk); check("lat_N1", {31'd0, valid_o}, 32'd0);
    @(negedge clk); check("lat_N2", {31'd0, valid_o}, 32'd1);
    drain();

    // Rounding cases with writeback always ready
    send(1'b0, 8'h80, 12'h7FC, 1'b1, 16'h4080, 3'b001, 1'b1); // carry into exp
    send(1'b0, 8'h81, 12'h7FC, 1'b1, 16'h4100, 3'b001, 1'b1); // carry into exp
    send(1'b0, 8'hFE, 12'h7FC, 1'b1, 16'h7F80, 3'b101, 1'b1); // overflow to inf
    send(1'b0, 8'hFF, 12'h600, 1'b0, 16'h7FC0, 3'b000, 1'b1); // QNaN pass-through
    send(1'b0, 8'h7F, 12'h504, 1'b1, 16'h3FA0, 3'b001, 1'b1); // tie, even stays
    send(1'b0, 8'h7F, 12'h50C, 1'b1, 16'h3FA2, 3'b001, 1'b1); // tie, odd rounds up
    send(1'b0, 8'h7F, 12'h508, 1'b1, 16'h3FA1, 3'b000, 1'b1); // exact
    send(1'b1, 8'h00, 12'h7FC, 1'b1, 16'h8000, 3'b011, 1'b1); // underflow
    send(1'b1, 8'h85, 12'h50C, 1'b1, 16'hC2A2, 3'b001, 1'b1); // negative
    drain();

    // Backpressure: two accepted, third dropped, FIFO contents preserved
    ready_i = 1'b0;
    send(1'b0, 8'h7F, 12'h0FF, 1'b1, 16'h3FA0, 3'b001, 1'b1);
    send(1'b0, 8'hFF, 12'h600, 1'b0, 16'h7FC0, 3'b000, 1'b1);
    send(1'b0, 8'hFE, 12'h7FC, 1'b1, 16'h7F80, 3'b101, 1'b0);
    check("drop_set", {31'd0, drop_o}, 32'd1);
    @(posedge clk); #1;
    check("full_valid", {31'd0, valid_o}, 32'd1);
    check("full_ready", {31'd0, ready_o}, 32'd0);
    heldRes = res_o;
    check("head_res", {16'd0, heldRes}, {16'd0, 16'h3FA0});
    repeat (2) @(posedge clk); #1;
    check("hold_res",   {16'd0, res_o},   {16'd0, 16'h3FA0});
    check("hold_flags", {29'd0, flags_o}, 32'd1);
    ready_i = 1'b1;
    drain();
    check("drop_sticky", {31'd0, drop_o}, 32'd1);

    // Reset with two entries buffered
    ready_i = 1'b0;
    send(1'b0, 8'h80, 12'h7FC, 1'b1, 16'h4080, 3'b001, 1'b1);
    send(1'b0, 8'h81, 12'h7FC, 1'b1, 16'h4100, 3'b001, 1'b1);
    expQ.delete();
    repeat (2) @(posedge clk); #1;
    check("pre_rst_valid", {31'd0, valid_o}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("post_rst_valid", {31'd0, valid_o}, 32'd0);
    check("post_rst_ready", {31'd0, ready_o}, 32'd1);
    check("post_rst_drop",  {31'd0, drop_o},  32'd0);
    ready_i = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("post_rst_idle", {31'd0, valid_o}, 32'd0);

    // Recovery after reset
    send(1'b1, 8'h85, 12'h50C, 1'b1, 16'hC2A2, 3'b001, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
